// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the output stream from the
// first beat of a packet until its last beat is accepted, through one register stage.
module packet_arbiter #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SOURCES-1:0]            in_valid,
  input  logic [NUM_SOURCES-1:0]            in_last,
  output logic [NUM_SOURCES-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic [NUM_SOURCES-1:0]            grant,
  output logic                              busy
);

  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SOURCES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [NUM_SOURCES-1:0]  grant_reg, grant_next;
  logic [PTR_W-1:0]        gidx_reg, gidx_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    out_last_reg, out_last_next;

  logic [DATA_WIDTH-1:0]   src_data [NUM_SOURCES];
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    pick_found;
  logic [PTR_W-1:0]        pick_idx;
  logic [NUM_SOURCES-1:0]  pick_oh;
  logic                    can_load;
  logic                    load_en;
  logic                    beat_acc;

  assign can_load = !out_valid_reg || out_ready;
  assign load_en  = (state_reg == BUSY) && can_load;

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign src_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign in_ready[gi] = grant_reg[gi] & load_en;
    end
  endgenerate

  // grant_reg is one-hot or zero, so an AND-OR mux selects the owner's beat
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_reg[i]) begin
        sel_data  = sel_data | src_data[i];
        sel_valid = sel_valid | in_valid[i];
        sel_last  = sel_last | in_last[i];
      end
    end
  end

  // Rotating priority: first pass covers ptr..N-1, second pass wraps to 0..ptr-1
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!pick_found && in_valid[i] && (i >= int'(ptr_reg))) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
        pick_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!pick_found && in_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(i);
        pick_oh[i] = 1'b1;
      end
    end
  end

  assign beat_acc = load_en && sel_valid;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    gidx_next      = gidx_reg;
    ptr_next       = ptr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;

    // Output stage drains independently of state so a pending last beat
    // can leave while IDLE arbitrates the next packet.
    if (beat_acc) begin
      out_data_next  = sel_data;
      out_last_next  = sel_last;
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_oh;
          gidx_next  = pick_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (beat_acc && sel_last) begin
          grant_next = '0;
          state_next = IDLE;
          ptr_next   = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      gidx_reg      <= '0;
      ptr_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      gidx_reg      <= gidx_next;
      ptr_reg       <= ptr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg == BUSY);

endmodule
